// File: rtl/ram_port_arbiter_if.sv
// Bundle of the requester-side and RAM-side signals of one shared RAM port.
// The slave modport is the arbiter's view; master is the requesters/RAM side.
interface ram_port_arbiter_if #(
   parameter int NREQ   = 3,
   parameter int DATA_W = 64,
   parameter int ADDR_W = 64
);
   logic [NREQ-1:0]        req;
   logic [NREQ-1:0]        last;
   logic [2*NREQ-1:0]      req_wr_rd;
   logic [ADDR_W*NREQ-1:0] req_addr;
   logic [DATA_W*NREQ-1:0] req_wdata;
   logic [NREQ-1:0]        gnt;
   logic [DATA_W-1:0]      to_ram;
   logic [ADDR_W-1:0]      address;
   logic [1:0]             WR_RD;
   logic [DATA_W-1:0]      from_ram;
   logic [DATA_W-1:0]      rdata;
   logic                   rdata_valid;
   logic [2:0]             rdata_id;
   logic                   err;

   modport slave (
      input  req, last, req_wr_rd, req_addr, req_wdata, from_ram,
      output gnt, to_ram, address, WR_RD, rdata, rdata_valid, rdata_id, err
   );

   modport master (
      output req, last, req_wr_rd, req_addr, req_wdata, from_ram,
      input  gnt, to_ram, address, WR_RD, rdata, rdata_valid, rdata_id, err
   );
endinterface

// File: rtl/ram_port_arbiter.sv
// Round-robin arbiter sharing one RAM port among NREQ requesters, with burst
// ownership, registered RAM-side outputs and owner-tagged read return.
// Build option: define RAM_PORT_ARB_FIXED_PRIORITY_EN to freeze the scan
// pointer at 0 (lowest index always wins each arbitration).
//
// state  | meaning
// -------+-----------------------------------------------
// S_IDLE | no grant, arbitrate every cycle
// S_OWN  | one requester owns the port (one-hot gnt)
module ram_port_arbiter #(
   parameter int NREQ      = 3,
   parameter int DATA_W    = 64,
   parameter int ADDR_W    = 64,
   parameter int MAX_BURST = 8
) (
   input logic              clk,
   input logic              rst,
   ram_port_arbiter_if.slave bus
);
   localparam int             IDW     = (NREQ > 1) ? $clog2(NREQ) : 1;
   localparam logic [IDW-1:0] LAST_ID = IDW'(NREQ - 1);
   localparam logic [7:0]     CNT_TC  = 8'(MAX_BURST - 1);
   localparam logic [0:0]     S_IDLE  = 1'b0;
   localparam logic [0:0]     S_OWN   = 1'b1;

   logic [0:0]        state_q, state_d;
   logic [NREQ-1:0]   gnt_q, gnt_d;
   logic [IDW-1:0]    owner_q, owner_d;
   logic [IDW-1:0]    ptr_q, ptr_d;
   logic [7:0]        cnt_q, cnt_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [DATA_W-1:0] wdata_q, wdata_d;
   logic [1:0]        op_q, op_d;
   logic [IDW-1:0]    op_id_q, op_id_d;
   logic              err_q, err_d;
   logic              rd_pend_q;
   logic [IDW-1:0]    rd_id_q;
   logic [DATA_W-1:0] rd_hold_q;
   logic [IDW-1:0]    win;
   logic              found, beat, rel, arb;
   logic [1:0]        own_op;

   // Decode the owner's cycle: beat, release and whether to arbitrate.
   always_comb begin
      own_op = bus.req_wr_rd[2*owner_q +: 2];
      beat   = (state_q == S_OWN) && bus.req[owner_q];
      rel    = (state_q == S_OWN) &&
               (!bus.req[owner_q] || (beat && (bus.last[owner_q] || cnt_q == CNT_TC)));
      arb    = (state_q == S_IDLE) || rel;
`ifdef RAM_PORT_ARB_FIXED_PRIORITY_EN
      // Pointer starts at 0 and is re-zeroed on every release: never moves.
      ptr_d  = rel ? '0 : ptr_q;
`else
      ptr_d  = rel ? ((owner_q == LAST_ID) ? '0 : owner_q + 1'b1) : ptr_q;
`endif
   end

   // Scan requests from the (possibly just advanced) pointer, wrapping.
   always_comb begin
      win   = '0;
      found = 1'b0;
      for (int k = 0; k < NREQ; k++) begin
         int idx;
         idx = int'(ptr_d) + k;
         if (idx >= NREQ) idx = idx - NREQ;
         if (!found && bus.req[idx]) begin
            found = 1'b1;
            win   = idx[IDW-1:0];
         end
      end
   end

   // Ownership next state: hand over with no bubble when someone is waiting.
   always_comb begin
      state_d = state_q;
      gnt_d   = gnt_q;
      owner_d = owner_q;
      cnt_d   = beat ? cnt_q + 8'd1 : cnt_q;
      if (arb) begin
         cnt_d = '0;
         gnt_d = '0;
         if (found) begin
            state_d    = S_OWN;
            gnt_d[win] = 1'b1;
            owner_d    = win;
         end else begin
            state_d = S_IDLE;
         end
      end
   end

   // RAM-side next values; op 11 is dropped to idle but still flags err.
   always_comb begin
      addr_d  = addr_q;
      wdata_d = wdata_q;
      op_d    = 2'b00;
      op_id_d = op_id_q;
      err_d   = err_q;
      if (beat) begin
         addr_d  = bus.req_addr[ADDR_W*owner_q +: ADDR_W];
         wdata_d = bus.req_wdata[DATA_W*owner_q +: DATA_W];
         op_id_d = owner_q;
         if (own_op == 2'b11) err_d = 1'b1;
         else                 op_d  = own_op;
      end
   end

   // State, grant and RAM-side registers.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= S_IDLE;
         gnt_q   <= '0;
         owner_q <= '0;
         ptr_q   <= '0;
         cnt_q   <= '0;
         addr_q  <= '0;
         wdata_q <= '0;
         op_q    <= 2'b00;
         op_id_q <= '0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         gnt_q   <= gnt_d;
         owner_q <= owner_d;
         ptr_q   <= ptr_d;
         cnt_q   <= cnt_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
         op_q    <= op_d;
         op_id_q <= op_id_d;
         err_q   <= err_d;
      end
   end

   // Read return: from_ram is live the cycle after a read op; hold it after.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         rd_pend_q <= 1'b0;
         rd_id_q   <= '0;
         rd_hold_q <= '0;
      end else begin
         rd_pend_q <= (op_q == 2'b01);
         if (op_q == 2'b01) rd_id_q <= op_id_q;
         if (rd_pend_q) rd_hold_q <= bus.from_ram;
      end
   end

   assign bus.gnt         = gnt_q;
   assign bus.to_ram      = wdata_q;
   assign bus.address     = addr_q;
   assign bus.WR_RD       = op_q;
   assign bus.err         = err_q;
   assign bus.rdata_valid = rd_pend_q;
   assign bus.rdata_id    = 3'(rd_id_q);
   assign bus.rdata       = rd_pend_q ? bus.from_ram : rd_hold_q;
endmodule

// File: tb/tb_ram_port_arbiter.sv
// Bench for ram_port_arbiter: NREQ=3, 64-bit data/address, MAX_BURST=4.
// Expected RAM ops and read returns are queued as stimulus is driven and
// checked as the DUT issues them; scenario tasks check grants/flags inline.
module tb_ram_port_arbiter;
   typedef struct { logic [1:0] op; logic [63:0] addr; logic [63:0] data; } op_t;
   typedef struct { logic [63:0] data; logic [2:0] id; } rd_t;

   logic clk = 1'b0;
   logic rst = 1'b0;
   int   checks = 0;
   int   errors = 0;

   op_t exp_ops[$];
   rd_t exp_rds[$];
   logic [63:0] exp_mem[logic [63:0]];
   logic [63:0] ram_mem[logic [63:0]];

   ram_port_arbiter_if #(.NREQ(3), .DATA_W(64), .ADDR_W(64)) bus ();

   ram_port_arbiter #(.NREQ(3), .DATA_W(64), .ADDR_W(64), .MAX_BURST(4)) dut (
      .clk(clk), .rst(rst), .bus(bus)
   );

   always #5 clk = ~clk;

   function automatic logic [63:0] default_word(input logic [63:0] a);
      return 64'hC0DE_0000_0000_0000 ^ a;
   endfunction

   function automatic logic [63:0] exp_read(input logic [63:0] a);
      return exp_mem.exists(a) ? exp_mem[a] : default_word(a);
   endfunction

   // Synchronous RAM model; from_ram is garbage except the cycle after a read.
   always @(posedge clk) begin
      if (bus.WR_RD == 2'b10) ram_mem[bus.address] = bus.to_ram;
      bus.from_ram <= (bus.WR_RD == 2'b01)
                      ? (ram_mem.exists(bus.address) ? ram_mem[bus.address] : default_word(bus.address))
                      : 64'hBAD0_BAD0_BAD0_BAD0;
   end

   // Scoreboard: pop expected op / read return when the DUT produces one.
   op_t sb_op;
   rd_t sb_rd;
   always @(negedge clk) begin
      if (rst && bus.WR_RD !== 2'b00) begin
         checks++;
         if (exp_ops.size() == 0) begin
            errors++;
            $display("FAIL ram_op unexpected WR_RD=%b address=%h", bus.WR_RD, bus.address);
         end else begin
            sb_op = exp_ops.pop_front();
            if (bus.WR_RD !== sb_op.op || bus.address !== sb_op.addr || bus.to_ram !== sb_op.data) begin
               errors++;
               $display("FAIL ram_op got %b/%h/%h expected %b/%h/%h", bus.WR_RD, bus.address,
                        bus.to_ram, sb_op.op, sb_op.addr, sb_op.data);
            end
         end
      end
      if (rst && bus.rdata_valid === 1'b1) begin
         checks++;
         if (exp_rds.size() == 0) begin
            errors++;
            $display("FAIL rd_ret unexpected rdata=%h id=%0d", bus.rdata, bus.rdata_id);
         end else begin
            sb_rd = exp_rds.pop_front();
            if (bus.rdata !== sb_rd.data || bus.rdata_id !== sb_rd.id) begin
               errors++;
               $display("FAIL rd_ret got %h id %0d expected %h id %0d", bus.rdata, bus.rdata_id,
                        sb_rd.data, sb_rd.id);
            end
         end
      end
   end

   task automatic set_req(input int i, input logic [1:0] op, input logic [63:0] a,
                          input logic [63:0] d, input logic l);
      bus.req_wr_rd[2*i +: 2] = op;
      bus.req_addr[64*i +: 64] = a;
      bus.req_wdata[64*i +: 64] = d;
      bus.last[i] = l;
   endtask

   task automatic push_op(input logic [1:0] op, input logic [63:0] a, input logic [63:0] d);
      exp_ops.push_back('{op: op, addr: a, data: d});
      if (op == 2'b10) exp_mem[a] = d;
   endtask

   task automatic push_rd(input logic [63:0] a, input logic [2:0] id);
      exp_rds.push_back('{data: exp_read(a), id: id});
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b0;
      bus.req = '0;
      bus.last = '0;
      bus.req_wr_rd = '0;
      bus.req_addr = '0;
      bus.req_wdata = '0;
      repeat (2) @(negedge clk);
      rst = 1'b1;
   endtask

   task automatic test_reset();
      do_reset();
      checks++;
      if (bus.gnt !== 3'b000 || bus.WR_RD !== 2'b00 || bus.err !== 1'b0) begin
         errors++;
         $display("FAIL reset_ctrl got gnt=%b WR_RD=%b err=%b expected 000/00/0", bus.gnt, bus.WR_RD, bus.err);
      end
      checks++;
      if (bus.address !== 64'h0 || bus.to_ram !== 64'h0) begin
         errors++;
         $display("FAIL reset_bus got address=%h to_ram=%h expected 0/0", bus.address, bus.to_ram);
      end
      checks++;
      if (bus.rdata !== 64'h0 || bus.rdata_valid !== 1'b0 || bus.rdata_id !== 3'd0) begin
         errors++;
         $display("FAIL reset_rd got rdata=%h valid=%b id=%0d expected 0/0/0", bus.rdata, bus.rdata_valid, bus.rdata_id);
      end
   endtask

   task automatic test_single();
      do_reset();
      set_req(0, 2'b10, 64'd5, 64'h2A, 1'b1);
      bus.req = 3'b001;
      push_op(2'b10, 64'd5, 64'h2A);
      @(negedge clk);
      checks++;
      if (bus.gnt !== 3'b001) begin
         errors++;
         $display("FAIL single_gnt got %b expected 001", bus.gnt);
      end
      @(negedge clk);
      checks++;
      if (bus.WR_RD !== 2'b10 || bus.address !== 64'd5 || bus.to_ram !== 64'h2A) begin
         errors++;
         $display("FAIL single_op got %b/%h/%h expected 10/5/2a", bus.WR_RD, bus.address, bus.to_ram);
      end
      bus.req = 3'b000;
      @(negedge clk);
      checks++;
      if (bus.gnt !== 3'b000 || bus.WR_RD !== 2'b00) begin
         errors++;
         $display("FAIL single_idle got gnt=%b WR_RD=%b expected 000/00", bus.gnt, bus.WR_RD);
      end
   endtask

   task automatic test_contention();
      logic [2:0] exp_g [4];
      exp_g = '{3'b001, 3'b010, 3'b100, 3'b001};
      do_reset();
      for (int i = 0; i < 3; i++) set_req(i, 2'b10, 64'h100 + 64'(i), 64'hA0 + 64'(i), 1'b1);
      bus.req = 3'b111;
      push_op(2'b10, 64'h100, 64'hA0);
      push_op(2'b10, 64'h101, 64'hA1);
      push_op(2'b10, 64'h102, 64'hA2);
      push_op(2'b10, 64'h100, 64'hA0);
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         checks++;
         if (bus.gnt !== exp_g[k]) begin
            errors++;
            $display("FAIL rr_gnt[%0d] got %b expected %b", k, bus.gnt, exp_g[k]);
         end
      end
      @(negedge clk);
      bus.req = 3'b000;
      @(negedge clk);
      checks++;
      if (bus.gnt !== 3'b000) begin
         errors++;
         $display("FAIL rr_idle got %b expected 000", bus.gnt);
      end
   endtask

   task automatic test_forced_release();
      int  n = 0;
      bit  done = 1'b0;
      do_reset();
      set_req(1, 2'b10, 64'h10, 64'h11, 1'b0);
      set_req(2, 2'b10, 64'h20, 64'h22, 1'b0);
      bus.req = 3'b110;
      repeat (4) push_op(2'b10, 64'h10, 64'h11);
      for (int c = 0; c < 20 && !done; c++) begin
         @(negedge clk);
         if (bus.gnt === 3'b010) n++;
         else if (n > 0) done = 1'b1;
      end
      checks++;
      if (!done) begin
         errors++;
         $display("FAIL burst_timeout got no handover expected gnt change within 20 cycles");
      end
      bus.req = 3'b000;
      checks++;
      if (n != 4) begin
         errors++;
         $display("FAIL burst_len got %0d expected 4", n);
      end
      checks++;
      if (bus.gnt !== 3'b100) begin
         errors++;
         $display("FAIL burst_next got %b expected 100", bus.gnt);
      end
      @(negedge clk);
      checks++;
      if (bus.gnt !== 3'b000) begin
         errors++;
         $display("FAIL burst_idle got %b expected 000", bus.gnt);
      end
   endtask

   task automatic test_read_tag();
      do_reset();
      set_req(2, 2'b10, 64'd7, 64'hDEAD, 1'b0);
      bus.req = 3'b100;
      push_op(2'b10, 64'd7, 64'hDEAD);
      @(negedge clk);
      checks++;
      if (bus.gnt !== 3'b100) begin
         errors++;
         $display("FAIL read_gnt got %b expected 100", bus.gnt);
      end
      @(negedge clk);
      set_req(2, 2'b01, 64'd7, 64'h5555, 1'b1);
      push_op(2'b01, 64'd7, 64'h5555);
      push_rd(64'd7, 3'd2);
      @(negedge clk);
      bus.req = 3'b000;
      @(negedge clk);
      checks++;
      if (bus.rdata_valid !== 1'b1 || bus.rdata !== 64'hDEAD || bus.rdata_id !== 3'd2) begin
         errors++;
         $display("FAIL read_ret got valid=%b rdata=%h id=%0d expected 1/dead/2", bus.rdata_valid, bus.rdata, bus.rdata_id);
      end
      @(negedge clk);
      checks++;
      if (bus.rdata_valid !== 1'b0 || bus.rdata !== 64'hDEAD) begin
         errors++;
         $display("FAIL read_hold got valid=%b rdata=%h expected 0/dead", bus.rdata_valid, bus.rdata);
      end
   endtask

   task automatic test_illegal();
      do_reset();
      set_req(0, 2'b11, 64'd3, 64'h33, 1'b1);
      bus.req = 3'b001;
      @(negedge clk);
      checks++;
      if (bus.gnt !== 3'b001 || bus.err !== 1'b0) begin
         errors++;
         $display("FAIL illegal_pre got gnt=%b err=%b expected 001/0", bus.gnt, bus.err);
      end
      @(negedge clk);
      checks++;
      if (bus.WR_RD !== 2'b00 || bus.err !== 1'b1) begin
         errors++;
         $display("FAIL illegal_op got WR_RD=%b err=%b expected 00/1", bus.WR_RD, bus.err);
      end
      set_req(1, 2'b10, 64'h40, 64'h44, 1'b1);
      bus.req = 3'b010;
      push_op(2'b10, 64'h40, 64'h44);
      @(negedge clk);
      checks++;
      if (bus.gnt !== 3'b010) begin
         errors++;
         $display("FAIL illegal_next got %b expected 010", bus.gnt);
      end
      @(negedge clk);
      bus.req = 3'b000;
      @(negedge clk);
      checks++;
      if (bus.err !== 1'b1) begin
         errors++;
         $display("FAIL err_sticky got %b expected 1", bus.err);
      end
   endtask

   task automatic test_reset_mid_burst();
      do_reset();
      set_req(0, 2'b01, 64'h50, 64'h0, 1'b0);
      bus.req = 3'b001;
      push_op(2'b01, 64'h50, 64'h0);
      push_op(2'b01, 64'h50, 64'h0);
      push_rd(64'h50, 3'd0);
      repeat (3) @(negedge clk);
      #1 rst = 1'b0;
      #1;
      checks++;
      if (bus.gnt !== 3'b000 || bus.WR_RD !== 2'b00 || bus.rdata_valid !== 1'b0) begin
         errors++;
         $display("FAIL midrst got gnt=%b WR_RD=%b valid=%b expected 000/00/0", bus.gnt, bus.WR_RD, bus.rdata_valid);
      end
      @(negedge clk);
      set_req(1, 2'b10, 64'h60, 64'h66, 1'b1);
      set_req(2, 2'b10, 64'h70, 64'h77, 1'b1);
      bus.req = 3'b110;
      push_op(2'b10, 64'h60, 64'h66);
      rst = 1'b1;
      @(negedge clk);
      checks++;
      if (bus.gnt !== 3'b010) begin
         errors++;
         $display("FAIL midrst_win got %b expected 010", bus.gnt);
      end
      @(negedge clk);
      bus.req = 3'b000;
      @(negedge clk);
      checks++;
      if (bus.gnt !== 3'b000 || bus.rdata_valid !== 1'b0) begin
         errors++;
         $display("FAIL midrst_idle got gnt=%b valid=%b expected 000/0", bus.gnt, bus.rdata_valid);
      end
   endtask

   initial begin
      bus.req = '0;
      bus.last = '0;
      bus.req_wr_rd = '0;
      bus.req_addr = '0;
      bus.req_wdata = '0;
      test_reset();
      test_single();
      test_contention();
      test_forced_release();
      test_read_tag();
      test_illegal();
      test_reset_mid_burst();
      repeat (3) @(negedge clk);
      checks++;
      if (exp_ops.size() != 0 || exp_rds.size() != 0) begin
         errors++;
         $display("FAIL sb_drain got %0d ops %0d reads pending expected 0 0", exp_ops.size(), exp_rds.size());
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/ram_port_arbiter.md
Name: ram_port_arbiter

Overview:
- Shares one RAM access port (to_ram/address/WR_RD) among NREQ requesters: header loader, solver core, result readout.
- Round-robin arbitration with burst ownership and registered RAM-side outputs.
- Read data returned tagged with the owner's index.
- One instance per RAM (four in the top level).

Parameters:
- NREQ, 3, number of requesters (2..8).
- DATA_W, 64, RAM data width.
- ADDR_W, 64, RAM address width.
- MAX_BURST, 8, maximum accepted beats per grant before forced release (1..255).

Ports:
- clk  input  1  system clock, all logic on rising edge.
- rst  input  1  asynchronous, active-low reset.
- req  input  NREQ  per-requester access request.
- last  input  NREQ  marks final beat of requester's burst.
- req_wr_rd  input  2*NREQ  per-requester op; slice i is bits [2i+1:2i].
- req_addr  input  ADDR_W*NREQ  per-requester address, slice i.
- req_wdata  input  DATA_W*NREQ  per-requester write data, slice i.
- gnt  output  NREQ  one-hot grant, registered.
- to_ram  output  DATA_W  write data to RAM, registered.
- address  output  ADDR_W  RAM address, registered.
- WR_RD  output  2  RAM op: bit1 write, bit0 read; 00 idle.
- from_ram  input  DATA_W  RAM read data, valid 1 cycle after read op.
- rdata  output  DATA_W  read data to requesters.
- rdata_valid  output  1  rdata valid strobe.
- rdata_id  output  3  index of requester owning rdata.
- err  output  1  sticky: illegal op 11 seen.

Behaviour:
- Reset (rst=0, async): gnt=0, to_ram=0, address=0, WR_RD=00, rdata=0, rdata_valid=0, rdata_id=0, err=0, rr pointer=0, beat count=0, state IDLE.
- States:
  - IDLE: no grant.
  - OWN: exactly one gnt bit high.
- Arbitration: scan req starting at pointer, wrapping modulo NREQ; first set bit wins. Winner's gnt is high in the cycle after the decision.
- IDLE -> OWN when any req=1. No req keeps IDLE and gnt=0.
- Beat: owner has gnt[i]=1 and req[i]=1 in the same cycle.
  - Next cycle: address=req_addr slice i, to_ram=req_wdata slice i, WR_RD=req_wr_rd slice i.
  - Beat count increments.
- Non-beat cycles in OWN: WR_RD=00; address and to_ram hold their previous values.
- Release condition, evaluated on the owner's cycle: beat with last[i]=1, OR beat count reaches MAX_BURST, OR req[i]=0.
  - On release: pointer=(i+1) mod NREQ, beat count=0.
  - Re-arbitrate in the same cycle with the new pointer. If another req is pending, gnt moves to the winner next cycle with no bubble; otherwise go to IDLE.
  - Released owner may win again only if it is the only requester.
- Forced release at MAX_BURST: the MAX_BURST-th beat is performed, then ownership is lost even if last=0.
- Read return:
  - Read beat (WR_RD=01 issued in cycle t): in t+1, rdata=from_ram, rdata_valid=1, rdata_id=owner index of that beat.
  - rdata_valid is a one-cycle pulse per read.
  - rdata holds its value between reads.
- Illegal op: req_wr_rd=11 on a beat is issued as WR_RD=00, err set to 1 (sticky until reset). The beat still counts toward the burst and toward release.
- gnt changes only on clock edges. Requesters must hold addr/wdata/wr_rd stable while req=1 and gnt=0.
- Mid-operation reset: all outputs go to reset values immediately and any in-flight read return is discarded (rdata_valid=0).
- NREQ=1: pointer stays 0; a single requester owns the port whenever req=1.

Optional Feature:
- Macro: RAM_PORT_ARB_FIXED_PRIORITY_EN.
- Defined: pointer is frozen at 0, so the lowest index always wins at each arbitration; burst and MAX_BURST rules are unchanged.
- Undefined: round-robin as described above.

Test Plan:
- Single requester: req[0]=1, wr_rd=10, addr=5, wdata=0x2A, last=1 -> gnt=001 next cycle; following cycle WR_RD=10, address=5, to_ram=0x2A; then gnt=000, state IDLE.
- Contention: req=111 held, each last=1 on first beat -> gnt sequence 001, 010, 100, 001 with no idle cycles.
- Forced release: MAX_BURST=4, req[1] and req[2] held, last=0 -> requester 1 gets exactly 4 beats, then gnt=100 in the next cycle.
- Read tagging: requester 2 reads addr 7, from_ram=0xDEAD -> two cycles after the beat, rdata=0xDEAD, rdata_valid=1 for one cycle, rdata_id=2.
- Illegal op: req_wr_rd=11 beat -> WR_RD=00 that cycle, err=1, err stays 1 across later legal traffic.
- Reset mid-burst: rst=0 during requester 0's third beat -> gnt=0, WR_RD=00, rdata_valid=0 immediately; after release, req=110 -> requester 1 wins (pointer=0, scan order 1 before 2).
